// File: rtl/regalu_sequencer.sv
// rtl/regalu_sequencer.sv - program-table micro-op sequencer driving the RegFile_Alu control inputs
module regalu_sequencer #(
    parameter int AW = 4,
    parameter int FW = 5
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          ProgWe,
    input  logic [AW-1:0] ProgAddr,
    input  logic [28:0]   ProgData,
    input  logic          Start,
    input  logic [AW:0]   Length,
    input  logic [FW-1:0] StopMask,
    input  logic [FW-1:0] Flags,
    output logic [3:0]    RdestRegLoc,
    output logic [3:0]    RsrcRegLoc,
    output logic [3:0]    OpCode,
    output logic [15:0]   Imm,
    output logic          Imm_s,
    output logic          En,
    output logic [AW-1:0] Pc,
    output logic          Busy,
    output logic          Done,
    output logic          Aborted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        state;
    logic [AW:0]   len_q;
    logic [FW-1:0] mask_q;
    logic [28:0]   mem [0:(1<<AW)-1];

    logic [AW:0]   len_in;
    logic [AW:0]   len_last;
    logic [AW-1:0] next_addr;
    logic [28:0]   next_entry;
    logic          flag_hit;
    logic          last_entry;

    always_comb begin
        len_in     = (Length > DEPTH) ? DEPTH : Length;
        len_last   = len_q - (AW+1)'(1);
        next_addr  = (state == IDLE) ? '0 : Pc + AW'(1);
        next_entry = mem[next_addr];
        flag_hit   = |(Flags & mask_q);
        last_entry = ({1'b0, Pc} == len_last);
    end

    // Table is deliberately not reset; writes are only accepted while idle.
    always_ff @(posedge Clk) begin
        if (ProgWe && state == IDLE) begin
            mem[ProgAddr] <= ProgData;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            len_q       <= '0;
            mask_q      <= '0;
            RdestRegLoc <= '0;
            RsrcRegLoc  <= '0;
            OpCode      <= '0;
            Imm         <= '0;
            Imm_s       <= 1'b0;
            En          <= 1'b0;
            Pc          <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Aborted     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        len_q   <= len_in;
                        mask_q  <= StopMask;
                        Aborted <= 1'b0;
                        if (len_in == '0) begin
                            Done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            OpCode      <= next_entry[28:25];
                            RdestRegLoc <= next_entry[24:21];
                            RsrcRegLoc  <= next_entry[20:17];
                            Imm_s       <= next_entry[16];
                            Imm         <= next_entry[15:0];
                            Pc          <= '0;
                            En          <= 1'b1;
                            Busy        <= 1'b1;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    // The entry being driven commits at this same edge even on abort.
                    if (flag_hit || last_entry) begin
                        En      <= 1'b0;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Aborted <= flag_hit;
                        state   <= FIN;
                    end else begin
                        OpCode      <= next_entry[28:25];
                        RdestRegLoc <= next_entry[24:21];
                        RsrcRegLoc  <= next_entry[20:17];
                        Imm_s       <= next_entry[16];
                        Imm         <= next_entry[15:0];
                        Pc          <= next_addr;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regalu_sequencer.sv
// tb/tb_regalu_sequencer.sv - directed and randomized bench with a register-file/ALU stand-in and run model
module tb_regalu_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        ProgWe = 1'b0;
    logic [3:0]  ProgAddr = '0;
    logic [28:0] ProgData = '0;
    logic        Start = 1'b0;
    logic [4:0]  Length = '0;
    logic [4:0]  StopMask = '0;
    logic [4:0]  Flags;
    logic [3:0]  RdestRegLoc, RsrcRegLoc, OpCode;
    logic [15:0] Imm;
    logic        Imm_s, En, Busy, Done, Aborted;
    logic [3:0]  Pc;

    regalu_sequencer #(.AW(4), .FW(5)) dut (
        .Clk(Clk), .Rst(Rst), .ProgWe(ProgWe), .ProgAddr(ProgAddr), .ProgData(ProgData),
        .Start(Start), .Length(Length), .StopMask(StopMask), .Flags(Flags),
        .RdestRegLoc(RdestRegLoc), .RsrcRegLoc(RsrcRegLoc), .OpCode(OpCode),
        .Imm(Imm), .Imm_s(Imm_s), .En(En), .Pc(Pc), .Busy(Busy), .Done(Done), .Aborted(Aborted)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;
    int en_cnt = 0;
    int done_cnt = 0;

    // ALU: A = Rdest, B = Imm or Rsrc; flags {0, parity, carry, negative, zero}
    function automatic logic [20:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        logic [4:0]  f;
        case (op)
            4'd0:    r = {1'b0, a} + {1'b0, b};
            4'd1:    r = {1'b0, a} - {1'b0, b};
            4'd2:    r = {1'b0, a & b};
            4'd3:    r = {1'b0, a | b};
            4'd4:    r = {1'b0, a ^ b};
            default: r = {1'b0, b};
        endcase
        f = {1'b0, ^r[15:0], r[16], r[15], (r[15:0] == 16'd0)};
        return {f, r[15:0]};
    endfunction

    logic [15:0] rf [16];
    logic [15:0] alu_res;
    logic        rf_clr = 1'b0;

    always_comb begin
        {Flags, alu_res} = alu(OpCode, rf[RdestRegLoc], Imm_s ? Imm : rf[RsrcRegLoc]);
    end

    always @(posedge Clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= 16'd0;
        end else if (En) begin
            rf[RdestRegLoc] <= alu_res;
        end
    end

    always @(posedge Clk) begin
        if (En) en_cnt++;
        if (Done) done_cnt++;
    end

    logic [28:0] prog [16];
    logic [15:0] mrf [16];
    logic [3:0]  last_pc = '0;
    logic [28:0] last_ctrl = '0;

    function automatic logic [28:0] mk(input int op, input int rd, input int rs, input int ims, input int imm);
        return {op[3:0], rd[3:0], rs[3:0], ims[0], imm[15:0]};
    endfunction

    function automatic logic [36:0] obs();
        return {En, Busy, Done, Aborted, Pc, OpCode, RdestRegLoc, RsrcRegLoc, Imm_s, Imm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic write_entry(input int a, input logic [28:0] d);
        ProgWe = 1'b1; ProgAddr = a[3:0]; ProgData = d;
        @(negedge Clk);
        ProgWe = 1'b0;
        prog[a] = d;
    endtask

    task automatic clear_regs();
        rf_clr = 1'b1;
        for (int i = 0; i < 16; i++) mrf[i] = 16'd0;
        @(negedge Clk);
        rf_clr = 1'b0;
    endtask

    // Run the table at the program level, then check the DUT cycle by cycle against it.
    task automatic do_run(input int len, input logic [4:0] mask, input int inject);
        int          l;
        int          idx[$];
        logic        ab;
        logic [20:0] fr;
        logic [28:0] e;
        int          en0, d0;
        l  = (len > 16) ? 16 : len;
        ab = 1'b0;
        for (int i = 0; i < l; i++) begin
            e  = prog[i];
            fr = alu(e[28:25], mrf[e[24:21]], e[16] ? e[15:0] : mrf[e[20:17]]);
            mrf[e[24:21]] = fr[15:0];
            idx.push_back(i);
            if ((fr[20:16] & mask) != 5'd0) begin
                ab = 1'b1;
                break;
            end
        end
        en0 = en_cnt; d0 = done_cnt;
        Start = 1'b1; Length = len[4:0]; StopMask = mask;
        @(negedge Clk);
        Start = 1'b0;
        for (int n = 0; n < idx.size(); n++) begin
            e = prog[idx[n]];
            chk("run_cycle", 64'(obs()), 64'({1'b1, 1'b1, 1'b0, 1'b0, 4'(idx[n]), e}));
            last_pc = 4'(idx[n]); last_ctrl = e;
            if (n == inject) begin
                Start = 1'b1; ProgWe = 1'b1; ProgAddr = 4'd2; ProgData = 29'($urandom);
            end
            @(negedge Clk);
            Start = 1'b0; ProgWe = 1'b0;
        end
        chk("done_cycle", 64'(obs()), 64'({1'b0, 1'b0, 1'b1, ab, last_pc, last_ctrl}));
        @(negedge Clk);
        chk("idle_after", 64'(obs()), 64'({1'b0, 1'b0, 1'b0, ab, last_pc, last_ctrl}));
        chk("en_cycles", 64'(en_cnt - en0), 64'(idx.size()));
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        for (int r = 0; r < 16; r++) chk("reg_value", 64'(rf[r]), 64'(mrf[r]));
    endtask

    initial begin
        logic [4:0] m;
        int         d0;
        repeat (3) @(negedge Clk);
        chk("reset_outputs", 64'(obs()), 64'd0);
        Rst = 1'b0;
        @(negedge Clk);
        clear_regs();

        // basic three-entry program
        write_entry(0, mk(0, 0, 0, 1, 1));
        write_entry(1, mk(0, 1, 0, 1, 2));
        write_entry(2, mk(0, 0, 1, 0, 0));
        do_run(3, 5'd0, -1);
        chk("basic_r0", 64'(rf[0]), 64'd3);
        chk("basic_r1", 64'(rf[1]), 64'd2);

        // zero-flag abort on entry 1
        clear_regs();
        write_entry(0, mk(0, 2, 0, 1, 5));
        write_entry(1, mk(1, 2, 0, 1, 5));
        write_entry(2, mk(0, 3, 0, 1, 7));
        write_entry(3, mk(0, 4, 0, 1, 9));
        do_run(4, 5'b00001, -1);
        repeat (3) @(negedge Clk);
        chk("aborted_holds", 64'(Aborted), 64'd1);

        // zero-length run clears Aborted and never enables
        do_run(0, 5'd0, -1);

        // over-range length clamps to a full table
        clear_regs();
        for (int i = 0; i < 16; i++) write_entry(i, 29'($urandom));
        do_run(31, 5'd0, -1);

        // Start and ProgWe during RUN are ignored
        clear_regs();
        write_entry(0, mk(0, 0, 0, 1, 1));
        write_entry(1, mk(0, 1, 0, 1, 2));
        write_entry(2, mk(0, 0, 1, 0, 0));
        do_run(3, 5'd0, 1);
        clear_regs();
        do_run(3, 5'd0, -1);
        chk("rerun_r0", 64'(rf[0]), 64'd3);

        // reset in the middle of a five-entry run
        clear_regs();
        for (int i = 0; i < 5; i++) write_entry(i, mk($urandom_range(0, 5), i, i + 1, 1, $urandom));
        d0 = done_cnt;
        Start = 1'b1; Length = 5'd5; StopMask = 5'd0;
        @(negedge Clk);
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        chk("pre_reset_pc", 64'(Pc), 64'd2);
        Rst = 1'b1;
        #1;
        chk("async_reset", 64'(obs()), 64'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("reset_no_done", 64'(done_cnt - d0), 64'd0);
        chk("reset_idle", 64'(obs()), 64'd0);
        last_pc = '0; last_ctrl = '0;
        clear_regs();
        do_run(5, 5'd0, -1);

        // randomized programs, lengths and stop masks
        for (int it = 0; it < 12; it++) begin
            clear_regs();
            for (int i = 0; i < 16; i++) write_entry(i, mk($urandom_range(0, 7), $urandom_range(0, 15),
                                                         $urandom_range(0, 15), $urandom_range(0, 1),
                                                         $urandom_range(0, 3)));
            m = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            do_run($urandom_range(0, 20), m, ($urandom_range(0, 3) == 0) ? 0 : -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
